// File: rtl/serial_rx_if.sv
// Serial receiver bundle: line input, consumer handshake and status flags.
interface serial_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 d;
  logic                 ready;
  logic                 clr_err;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;

  // Receiver side
  modport slave (
    input  d, ready, clr_err,
    output data, valid, busy, frame_err, overrun
  );

  // Line driver / consumer side
  modport master (
    output d, ready, clr_err,
    input  data, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/serial_rx.sv
// Oversampled async serial receiver with a one-word holding register,
// sticky framing/overrun flags and a valid/ready consumer handshake.
module serial_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic        clock,
  input  logic        nreset,
  serial_rx_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  state_t               state, state_n;
  logic                 sync1, ds;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q;
  logic                 deliver, ferr_evt;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clock) begin
    if (!nreset) begin
      sync1 <= 1'b1;
      ds    <= 1'b1;
    end else begin
      sync1 <= bus.d;
      ds    <= sync1;
    end
  end

  // FSM, bit-time counter and shift register state
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  // Next-state: mid-bit sampling, LSB first; deliver or flag at the stop bit
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    sh_n     = shreg;
    deliver  = 1'b0;
    ferr_evt = 1'b0;
    case (state)
      IDLE: begin
        if (!ds) begin
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = ds ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          sh_n  = {ds, shreg[DATA_BITS-1:1]};
          if (bit_idx == LAST_BIT) state_n = STOP;
          else                     bit_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n = '0;
          if (ds) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_evt = 1'b1;
            state_n  = WAITHI;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAITHI: begin
        if (ds) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register, handshake and sticky flags (set beats clear)
  always_ff @(posedge clock) begin
    if (!nreset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (deliver && (!valid_q || bus.ready)) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
      if (bus.clr_err) begin
        ferr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (ferr_evt)                          ferr_q <= 1'b1;
      if (deliver && valid_q && !bus.ready)  ovr_q  <= 1'b1;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state != IDLE);
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: table of frames plus hand-written corner cases.
module tb_serial_rx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   rise_cyc = 0;
  int   xfers = 0;
  logic [7:0] last_x = '0;
  logic prev_v = 1'b0;

  serial_rx_if #(.DATA_BITS(8)) bus ();

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock  (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer-side monitor: counts handshakes and records valid rise time
  always @(negedge clk) begin
    if (nreset && bus.valid && bus.ready) begin
      xfers  <= xfers + 1;
      last_x <= bus.data;
    end
    if (bus.valid && !prev_v) rise_cyc <= cyc;
    prev_v <= bus.valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] val;
    bit         stop;
    bit         rdy;
    bit         clr;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_ferr;
    bit         e_ovr;
    int         e_xfers;
    logic [7:0] e_last;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input bit stop);
    @(posedge clk); #1;
    bus.d   = 1'b0;
    t_start = cyc;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      bus.d = v[i];
      repeat (CPB) @(posedge clk); #1;
    end
    bus.d = stop;
    repeat (CPB) @(posedge clk); #1;
    if (!stop) begin
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("waithi_busy", bus.busy, 1);
      chk("waithi_no_valid", bus.valid, 0);
      @(posedge clk); #1;
    end
    bus.d = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 bus.clr_err = 1'b1;
    @(posedge clk); #1 bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.d = 1'b1;
    bus.ready = 1'b0;
    bus.clr_err = 1'b0;

    //          val    stop rdy clr  e_data e_v e_fe e_ov xfers last
    tbl[0] = '{8'hA5, 1, 1, 0, 8'hA5, 0, 0, 0, 1, 8'hA5};
    tbl[1] = '{8'h3C, 0, 1, 0, 8'hA5, 0, 1, 0, 1, 8'hA5};
    tbl[2] = '{8'h81, 1, 1, 0, 8'h81, 0, 1, 0, 2, 8'h81};
    tbl[3] = '{8'h11, 1, 0, 1, 8'h11, 1, 0, 0, 2, 8'h81};
    tbl[4] = '{8'h22, 1, 0, 0, 8'h11, 1, 0, 1, 2, 8'h81};

    // Reset state
    repeat (3) @(posedge clk); #1 nreset = 1'b1;
    @(negedge clk);
    chk("rst_data", bus.data, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_ovr", bus.overrun, 0);

    // Glitch: one low cycle enters START then aborts at mid-bit
    @(posedge clk); #1 bus.d = 1'b0;
    @(posedge clk); #1 bus.d = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_start", bus.busy, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_end", bus.busy, 0);
    chk("glitch_valid", bus.valid, 0);
    chk("glitch_ferr", bus.frame_err, 0);
    chk("glitch_ovr", bus.overrun, 0);

    // Table-driven frames: normal, framing error, recovery, overrun
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 bus.ready = tbl[i].rdy;
      send_frame(tbl[i].val, tbl[i].stop);
      if (tbl[i].clr) pulse_clr();
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_data", i), bus.data, tbl[i].e_data);
      chk($sformatf("v%0d_valid", i), bus.valid, tbl[i].e_valid);
      chk($sformatf("v%0d_ferr", i), bus.frame_err, tbl[i].e_ferr);
      chk($sformatf("v%0d_ovr", i), bus.overrun, tbl[i].e_ovr);
      chk($sformatf("v%0d_xfers", i), xfers, tbl[i].e_xfers);
      chk($sformatf("v%0d_last", i), last_x, tbl[i].e_last);
      chk($sformatf("v%0d_busy", i), bus.busy, 0);
      if (i == 0)
        chk("latency_in_range", ((rise_cyc - t_start) >= 39) && ((rise_cyc - t_start) <= 41), 1);
    end

    // Drain held word, then clear overrun
    @(posedge clk); #1 bus.ready = 1'b1;
    @(posedge clk); #1 bus.ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("drain_valid", bus.valid, 0);
    chk("drain_xfers", xfers, 3);
    chk("drain_last", last_x, 8'h11);
    chk("drain_ovr_sticky", bus.overrun, 1);
    pulse_clr();
    @(negedge clk);
    chk("clr_ovr", bus.overrun, 0);
    chk("clr_ferr", bus.frame_err, 0);

    // Transfer and delivery in the same cycle (stop sample is edge 41)
    send_frame(8'h11, 1'b1);
    @(negedge clk);
    chk("hold_valid", bus.valid, 1);
    chk("hold_data", bus.data, 8'h11);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (40) @(posedge clk); #1 bus.ready = 1'b1;
        @(posedge clk); #1 bus.ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("simul_data", bus.data, 8'h55);
    chk("simul_valid", bus.valid, 1);
    chk("simul_ovr", bus.overrun, 0);
    chk("simul_xfers", xfers, 4);
    chk("simul_last", last_x, 8'h11);

    // Reset during DATA bit 3; remaining bits are 1 so no new start appears
    fork
      send_frame(8'hF8, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (18) @(posedge clk); #1 nreset = 1'b0;
        @(posedge clk); #1 nreset = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", bus.data, 0);
        chk("mid_rst_valid", bus.valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ferr", bus.frame_err, 0);
        chk("mid_rst_ovr", bus.overrun, 0);
      end
    join
    repeat (2) @(negedge clk);
    chk("post_rst_valid", bus.valid, 0);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_data", bus.data, 0);
    chk("post_rst_ferr", bus.frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit; legal values are even and >= 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range is 5-8.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 nreset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 d  input  1  asynchronous serial line; idles high.
REQ-006 ready  input  1  consumer accepts data when ready=1 and valid=1 in the same cycle.
REQ-007 clr_err  input  1  a one-cycle pulse clears frame_err and overrun.
REQ-008 data  output  DATA_BITS  the last received word, held stable while valid=1.
REQ-009 valid  output  1  data holds an unconsumed word.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_err  output  1  sticky; a stop bit was sampled as 0.
REQ-012 overrun  output  1  sticky; a word was dropped because the holding register was full.

Function
REQ-013 d SHALL pass through a 2-flop synchronizer (ds); all FSM decisions use ds only.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP and WAITHI.
REQ-015 IDLE: when ds=0, go to START and clear the bit-time counter; otherwise stay in IDLE.
REQ-016 START: at counter = CLKS_PER_BIT/2-1 (mid start bit), go to DATA if ds=0, else return to IDLE as a glitch with no flags set.
REQ-017 DATA: sample ds every CLKS_PER_BIT cycles after the mid-start point, LSB first, into the shift register; after DATA_BITS samples go to STOP.
REQ-018 STOP: sample ds CLKS_PER_BIT cycles after the last data sample.
- If ds=1, deliver the word per REQ-019/020 and go to IDLE.
- If ds=0, set frame_err, discard the word and go to WAITHI.
REQ-019 Delivery with valid=0, or with valid=1 and ready=1 in the same cycle: data loads the new word and valid is 1 on the next cycle; no overrun.
REQ-020 Delivery with valid=1 and ready=0: data and valid are unchanged, and overrun is set.
REQ-021 WAITHI: stay until ds=1, then go to IDLE; a line held low never re-triggers reception.
REQ-022 A transfer (valid=1, ready=1) with no simultaneous delivery SHALL clear valid on the next cycle.
REQ-023 Latency: valid SHALL rise 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles (±1) after the falling edge of d, when sampled at clock.
REQ-024 clr_err SHALL clear the flags on the next cycle; if an error event happens in the same cycle as clr_err, the flag is set (set wins).
REQ-025 ready SHALL have no effect while valid=0.
REQ-026 The counter width SHALL be clog2(CLKS_PER_BIT); the counter wraps to 0 at each sample point.

Reset
REQ-027 With nreset=0 at a rising edge, the block SHALL go to IDLE and set data=0, valid=0, busy=0, frame_err=0, overrun=0, counter=0, shift register=0, and both synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abort the frame with no delivery and no flag.
REQ-029 After reset is released, reception SHALL start only on a new falling edge of ds.

Verification
REQ-030 The bench SHALL cover a normal frame: with defaults, send start, 0xA5 LSB first, stop, ready=1 -> valid pulses for one cycle with data=8'hA5 and no flags.
REQ-031 The bench SHALL cover a glitch: d low for 1 cycle, then high -> START aborts, busy returns to 0, valid=0, flags=0.
REQ-032 The bench SHALL cover a framing error: send 0x3C with stop bit=0 and d held low for 20 cycles -> frame_err=1, valid=0, FSM held in WAITHI; then d=1 and frame 0x81 -> data=8'h81 with frame_err still 1 until a clr_err pulse.
REQ-033 The bench SHALL cover overrun: ready=0, send 0x11 then 0x22 -> data=8'h11, valid=1, overrun=1; then ready=1 -> valid drops, and clr_err clears overrun.
REQ-034 The bench SHALL cover simultaneous transfer and delivery: ready rises in the exact STOP-sample cycle of the second frame 0x55 while 0x11 is held -> data=8'h55, valid stays 1, overrun=0.
REQ-035 The bench SHALL cover reset mid-frame: nreset=0 for 1 cycle during DATA bit 3 -> all outputs 0 next cycle, and no delivery for the rest of that frame.
